cpu_state_dump: RTL and testbench

Synthesizable run-then-dump controller for the single-cycle cpu; the team's generalised replacement for fixed-delay register and memory printouts. It lets the cpu run for a programmable cycle window or until a halt request, then stalls it. It then streams every register-file word followed by a configurable data-memory window over a valid/ready channel to a trace sink, either a UART bridge or a bench monitor.

---
 rtl/cpu_dbg_pkg.sv | 20 ++
 rtl/dump_out_reg.sv | 82 ++++++++
 rtl/cpu_state_dump.sv | 172 +++++++++++++++++
 tb/tb_cpu_state_dump.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared types and constants for the cpu debug/trace blocks.
//   dump_state_e : run-then-dump controller states
//   KIND_REG/MEM : out_kind encoding on the trace stream
//   DEFAULT_XLEN : default data width for register file and data memory
package cpu_dbg_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DUMP_REG = 3'd2,
    ST_DUMP_MEM = 3'd3,
    ST_DONE     = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: single-entry valid/ready output register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture in_* as a new beat (only asserted while free)
//   clr             : clear the sticky last flag once nothing is in flight
//   in_data/kind/index/last : beat to capture
//   out_ready       : sink accepts the presented beat
//   free            : register can take a new beat this cycle
//   out_valid/data/kind/index/last : presented beat, held while stalled
module dump_out_reg #(
  parameter int W    = 32,
  parameter int IW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clr,
  input  logic [W-1:0]  in_data,
  input  logic          in_kind,
  input  logic [IW-1:0] in_index,
  input  logic          in_last,
  input  logic          out_ready,
  output logic          free,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_kind,
  output logic [IW-1:0] out_index,
  output logic          out_last
);

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
  logic          kind_q,  kind_d;
  logic [IW-1:0] index_q, index_d;
  logic          last_q,  last_d;

  // Empty, or the current beat leaves on this edge: a new one may replace it.
  assign free = !valid_q || out_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    kind_d  = kind_q;
    index_d = index_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      kind_d  = in_kind;
      index_d = in_index;
      last_d  = in_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (clr && !valid_q) begin
      last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      kind_q  <= 1'b0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_kind  = kind_q;
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: rtl/cpu_state_dump.sv
// cpu_state_dump: run-then-dump controller for the single-cycle cpu.
// Lets the cpu run for RUN_CYCLES+1 cycles (or until halt_req), stalls it,
// then streams NREGS register words followed by NMEM data-memory words
// (starting at MEM_BASE) over a valid/ready channel.
//   clk, reset          : clock, asynchronous active-low reset
//   start, halt_req     : begin run window / end it early
//   cpu_stall           : freezes the cpu while dumping and after
//   rf_raddr/rf_rdata   : register-file debug read port (combinational)
//   dm_raddr/dm_rdata   : data-memory debug read port (combinational)
//   out_valid/ready/data/kind/index/last : trace stream to the sink
//   busy, done          : controller active / dump fully delivered
module cpu_state_dump
  import cpu_dbg_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int NREGS      = 32,
  parameter int NMEM       = 32,
  parameter int MEM_BASE   = 0,
  parameter int RUN_CYCLES = 50,
  parameter int ZERO_X0    = 1,
  parameter int IDXW       = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     halt_req,
  output logic                                     cpu_stall,
  output logic [((NREGS > 1) ? $clog2(NREGS) : 1)-1:0] rf_raddr,
  input  logic [XLEN-1:0]                          rf_rdata,
  output logic [IDXW-1:0]                          dm_raddr,
  input  logic [XLEN-1:0]                          dm_rdata,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [XLEN-1:0]                          out_data,
  output logic                                     out_kind,
  output logic [IDXW-1:0]                          out_index,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     done
);

  localparam int RAW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int MAXN = (NREGS > NMEM) ? NREGS : NMEM;
  localparam int IW   = $clog2(MAXN + 1);

  dump_state_e   state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [31:0]   cnt_q,   cnt_d;

  logic            load;
  logic            clr;
  logic            free;
  logic [XLEN-1:0] ld_data;
  logic            ld_kind;
  logic [IDXW-1:0] ld_index;
  logic            ld_last;
  logic [IDXW-1:0] mem_addr;

  // Word address of the memory beat being fetched; wraps modulo 2^IDXW.
  assign mem_addr = IDXW'(MEM_BASE) + IDXW'(idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    clr      = 1'b0;
    ld_data  = '0;
    ld_kind  = KIND_REG;
    ld_index = '0;
    ld_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = 32'(RUN_CYCLES);
        end else if (halt_req) begin
          state_d = ST_DUMP_REG;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        // The cycle that sees cnt==0 is the last run cycle, hence RUN_CYCLES+1.
        if (halt_req || cnt_q == 32'd0) begin
          state_d = ST_DUMP_REG;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_DUMP_REG: begin
        if (free) begin
          load     = 1'b1;
          ld_data  = (ZERO_X0 != 0 && idx_q == '0) ? '0 : rf_rdata;
          ld_kind  = KIND_REG;
          ld_index = IDXW'(idx_q);
          // Switch straight to memory so the next cycle loads its first word.
          if (idx_q == IW'(NREGS - 1)) begin
            state_d = ST_DUMP_MEM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DUMP_MEM: begin
        if (free) begin
          load     = 1'b1;
          ld_data  = dm_rdata;
          ld_kind  = KIND_MEM;
          ld_index = mem_addr;
          ld_last  = (idx_q == IW'(NMEM - 1));
          if (ld_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = 32'(RUN_CYCLES);
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  dump_out_reg #(
    .W  (XLEN),
    .IW (IDXW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load),
    .clr       (clr),
    .in_data   (ld_data),
    .in_kind   (ld_kind),
    .in_index  (ld_index),
    .in_last   (ld_last),
    .out_ready (out_ready),
    .free      (free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_index (out_index),
    .out_last  (out_last)
  );

  assign cpu_stall = (state_q == ST_DUMP_REG) || (state_q == ST_DUMP_MEM) ||
                     (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  // The last beat has left once DONE is reached and nothing is presented.
  assign done      = (state_q == ST_DONE) && !out_valid;
  assign rf_raddr  = (state_q == ST_DUMP_REG) ? RAW'(idx_q) : '0;
  assign dm_raddr  = (state_q == ST_DUMP_MEM) ? mem_addr : IDXW'(MEM_BASE);

endmodule

// File: tb/tb_cpu_state_dump.sv
// Scoreboard bench for cpu_state_dump. Two instances:
//   dut_a : default sizes (32 regs, 32 mem words, base 0, RUN_CYCLES 50)
//   dut_b : 4 regs, 4 mem words at base 0x10, RUN_CYCLES 0
// Stimulus pushes the expected beat list; negedge monitors pop and compare.
module tb_cpu_state_dump;

  typedef struct packed {
    logic [31:0] data;
    logic        kind;
    logic [15:0] index;
    logic        last;
  } beat_t;

  logic clk;
  logic reset;

  logic        start_a, halt_a, stall_a, valid_a, ready_a, kind_a, last_a, busy_a, done_a;
  logic [4:0]  rf_raddr_a;
  logic [31:0] rf_rdata_a, dm_rdata_a, data_a;
  logic [15:0] dm_raddr_a, index_a;

  logic        start_b, halt_b, stall_b, valid_b, ready_b, kind_b, last_b, busy_b, done_b;
  logic [1:0]  rf_raddr_b;
  logic [31:0] rf_rdata_b, dm_rdata_b, data_b;
  logic [15:0] dm_raddr_b, index_b;

  int checks;
  int failures;
  int beats_a;
  int beats_b;
  beat_t sb_a[$];
  beat_t sb_b[$];

  logic       bp_mode;
  logic [3:0] bp_pat;
  int         bp_ph;

  // Register x0 returns garbage so the zero-forcing of index 0 is visible.
  assign rf_rdata_a = (rf_raddr_a == 5'd0) ? 32'hDEAD_BEEF : 32'(rf_raddr_a) * 3;
  assign dm_rdata_a = 32'hA000 + 32'(dm_raddr_a);
  assign rf_rdata_b = (rf_raddr_b == 2'd0) ? 32'hDEAD_BEEF : 32'(rf_raddr_b) * 3;
  assign dm_rdata_b = 32'hA000 + 32'(dm_raddr_b);
  assign ready_b    = 1'b1;

  cpu_state_dump dut_a (
    .clk(clk), .reset(reset), .start(start_a), .halt_req(halt_a),
    .cpu_stall(stall_a), .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
    .dm_raddr(dm_raddr_a), .dm_rdata(dm_rdata_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_data(data_a), .out_kind(kind_a),
    .out_index(index_a), .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  cpu_state_dump #(
    .NREGS(4), .NMEM(4), .MEM_BASE(16), .RUN_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .halt_req(halt_b),
    .cpu_stall(stall_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .dm_raddr(dm_raddr_b), .dm_rdata(dm_rdata_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_data(data_b), .out_kind(kind_b),
    .out_index(index_b), .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.data = (i == 0) ? 32'd0 : 32'(i * 3);
      b.kind = 1'b0; b.index = 16'(i); b.last = 1'b0;
      sb_a.push_back(b);
    end
    for (int i = 0; i < 32; i++) begin
      b.data = 32'hA000 + 32'(i);
      b.kind = 1'b1; b.index = 16'(i); b.last = (i == 31);
      sb_a.push_back(b);
    end
  endtask

  task automatic push_b();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.data = (i == 0) ? 32'd0 : 32'(i * 3);
      b.kind = 1'b0; b.index = 16'(i); b.last = 1'b0;
      sb_b.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      b.data = 32'hA010 + 32'(i);
      b.kind = 1'b1; b.index = 16'h10 + 16'(i); b.last = (i == 3);
      sb_b.push_back(b);
    end
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin tick(); n++; end
    check("done_a_reached", 64'(done_a), 64'd1);
    check("sb_a_drained", 64'(sb_a.size()), 64'd0);
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    while (!done_b && n < budget) begin tick(); n++; end
    check("done_b_reached", 64'(done_b), 64'd1);
    check("sb_b_drained", 64'(sb_b.size()), 64'd0);
  endtask

  // Backpressure pattern 1,0,0,1 repeating, otherwise ready held high.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ready_a = bp_pat[bp_ph];
      bp_ph   = (bp_ph + 1) % 4;
    end else begin
      ready_a = 1'b1;
    end
  end

  // Monitor A: pops on each transfer, and checks held beats stay stable.
  beat_t held_a;
  logic  hold_a;
  always @(negedge clk) begin
    beat_t cur, exp;
    cur = '{data: data_a, kind: kind_a, index: index_a, last: last_a};
    if (!reset) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a && valid_a) check("a_stable_under_stall", 64'(cur), 64'(held_a));
      if (valid_a && ready_a) begin
        if (sb_a.size() == 0) begin
          check("a_unexpected_beat", 64'(cur), 64'd0);
        end else begin
          exp = sb_a.pop_front();
          check($sformatf("a_beat%0d", beats_a), 64'(cur), 64'(exp));
        end
        beats_a++;
        hold_a = 1'b0;
      end else if (valid_a) begin
        hold_a = 1'b1;
        held_a = cur;
      end else begin
        hold_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    beat_t cur, exp;
    cur = '{data: data_b, kind: kind_b, index: index_b, last: last_b};
    if (reset && valid_b) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_beat", 64'(cur), 64'd0);
      end else begin
        exp = sb_b.pop_front();
        check($sformatf("b_beat%0d", beats_b), 64'(cur), 64'(exp));
      end
      beats_b++;
    end
  end

  task automatic check_reset_a(input string tag);
    check({tag, "_stall"},  64'(stall_a),    64'd0);
    check({tag, "_rfaddr"}, 64'(rf_raddr_a), 64'd0);
    check({tag, "_dmaddr"}, 64'(dm_raddr_a), 64'd0);
    check({tag, "_valid"},  64'(valid_a),    64'd0);
    check({tag, "_data"},   64'(data_a),     64'd0);
    check({tag, "_kind"},   64'(kind_a),     64'd0);
    check({tag, "_index"},  64'(index_a),    64'd0);
    check({tag, "_last"},   64'(last_a),     64'd0);
    check({tag, "_busy"},   64'(busy_a),     64'd0);
    check({tag, "_done"},   64'(done_a),     64'd0);
  endtask

  initial begin
    int base;
    checks = 0; failures = 0; beats_a = 0; beats_b = 0;
    hold_a = 1'b0; bp_mode = 1'b0; bp_pat = 4'b1001; bp_ph = 0;
    ready_a = 1'b1;
    start_a = 0; halt_a = 0; start_b = 0; halt_b = 0;
    reset = 1'b0;
    #3;
    check_reset_a("por");
    check("por_b_dmaddr", 64'(dm_raddr_b), 64'h10);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Run window of 51 cycles, then 64 beats back to back.
    push_a();
    start_a = 1; tick(); start_a = 0;           // E0
    check("run_busy", 64'(busy_a), 64'd1);
    repeat (50) tick();                          // E0+50
    check("run_stall_e50", 64'(stall_a), 64'd0);
    tick();                                      // E0+51
    check("run_stall_e51", 64'(stall_a), 64'd1);
    check("run_valid_e51", 64'(valid_a), 64'd0);
    tick();                                      // E0+52
    check("run_valid_e52", 64'(valid_a), 64'd1);
    repeat (63) tick();                          // E0+115
    check("last_beat_valid", 64'(valid_a), 64'd1);
    check("last_beat_last", 64'(last_a), 64'd1);
    check("last_beat_done", 64'(done_a), 64'd0);
    tick();                                      // E0+116
    check("done_after_last", 64'(done_a), 64'd1);
    check("valid_after_last", 64'(valid_a), 64'd0);
    wait_done_a(5);

    // Restart from DONE, halted early after 5 run cycles.
    push_a();
    start_a = 1; tick(); start_a = 0;
    check("restart_done_clr", 64'(done_a), 64'd0);
    check("restart_last_clr", 64'(last_a), 64'd0);
    check("restart_stall", 64'(stall_a), 64'd0);
    repeat (4) tick();
    halt_a = 1; tick(); halt_a = 0;
    check("halt_stall", 64'(stall_a), 64'd1);
    wait_done_a(200);

    // Backpressure across the whole stream.
    bp_mode = 1'b1;
    push_a();
    start_a = 1; tick(); start_a = 0;
    wait_done_a(400);
    bp_mode = 1'b0;

    // Reset in the middle of the dump, then a fresh full dump.
    push_a();
    base = beats_a;
    start_a = 1; tick(); start_a = 0;
    for (int n = 0; n < 200 && beats_a < base + 20; n++) tick();
    check("reach_beat20", 64'(beats_a >= base + 20), 64'd1);
    #1 reset = 1'b0;
    #1 check_reset_a("mid");
    sb_a.delete();
    tick();
    reset = 1'b1;
    tick();
    push_a();
    start_a = 1; tick(); start_a = 0;
    wait_done_a(200);

    // RUN_CYCLES=0, start and halt together, small memory window at 0x10.
    push_b();
    start_b = 1; halt_b = 1; tick(); start_b = 0; halt_b = 0;
    check("b_run_busy", 64'(busy_b), 64'd1);
    check("b_run_stall", 64'(stall_b), 64'd0);
    tick();
    check("b_dump_stall", 64'(stall_b), 64'd1);
    wait_done_b(50);

    push_b();
    start_b = 1; tick(); start_b = 0;
    check("b_restart_done_clr", 64'(done_b), 64'd0);
    wait_done_b(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
